// File: rtl/modops_pkg.sv
// Shared constants, FSM state encoding and LFSR step for the modular-op vector source.
package modops_pkg;

   localparam int          DEF_DW    = 12;
   localparam int          DEF_Q     = 3329;
   localparam logic [15:0] LFSR_MASK = 16'hB400;
   localparam logic [15:0] DEF_SEED  = 16'hACE1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GEN_A = 3'd1,
      ST_GEN_B = 3'd2,
      ST_MUL   = 3'd3,
      ST_OUT   = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   // Right-shifting Galois step; the mask is folded in when bit 0 falls out.
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
   endfunction

endpackage

// File: rtl/mod_addsub_q.sv
// Single-correction modular add/subtract for operands already reduced into [0, Q).
module mod_addsub_q
   import modops_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int Q  = DEF_Q
)(
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          sub,
   output logic [DW-1:0] y
);

   localparam logic [DW:0] Q_W = (DW+1)'(Q);

   logic [DW:0] sum_s;
   logic [DW:0] diff_s;

   assign sum_s  = {1'b0, a} + {1'b0, b};
   assign diff_s = {1'b0, a} - {1'b0, b};

   // Top bit of diff_s is the borrow, so a < b is detected without a separate compare.
   always_comb begin
      y = {DW{1'b0}};
      if (sub) begin
         if (diff_s[DW]) begin
            y = DW'(diff_s + Q_W);
         end else begin
            y = diff_s[DW-1:0];
         end
      end else begin
         if (sum_s >= Q_W) begin
            y = DW'(sum_s - Q_W);
         end else begin
            y = sum_s[DW-1:0];
         end
      end
   end

endmodule

// File: rtl/modops_vec_gen.sv
// Pseudo-random / directed operand source with golden modular add, sub, half and mul
// results, streamed out one vector at a time over valid/ready.
module modops_vec_gen
   import modops_pkg::*;
#(
   parameter int          DW      = DEF_DW,
   parameter int          Q       = DEF_Q,
   parameter logic [15:0] SEED    = DEF_SEED,
   parameter int          NUM_VEC = 1024
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          fixed,
   input  logic [DW-1:0] fix_a,
   input  logic [DW-1:0] fix_b,
   output logic          busy,
   output logic          done,
   output logic          vld,
   input  logic          rdy,
   output logic [15:0]   idx,
   output logic [DW-1:0] op_a,
   output logic [DW-1:0] op_b,
   output logic [DW-1:0] exp_add,
   output logic [DW-1:0] exp_sub,
   output logic [DW-1:0] exp_half,
   output logic [DW-1:0] exp_mul
);

   localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam int            BW       = $clog2(DW);
   localparam logic [BW-1:0] BIT_TOP  = BW'(DW-1);
   localparam logic [DW-1:0] Q_D      = DW'(Q);
   localparam logic [DW:0]   Q_W      = (DW+1)'(Q);
   localparam logic [15:0]   IDX_LAST = 16'(NUM_VEC-1);

   state_t          state_r;
   state_t          state_next_s;
   logic [15:0]     lfsr_r;
   logic [15:0]     idx_r;
   logic            fixed_r;
   logic [DW-1:0]   op_a_r;
   logic [DW-1:0]   op_b_r;
   logic [DW-1:0]   exp_add_r;
   logic [DW-1:0]   exp_sub_r;
   logic [DW-1:0]   exp_half_r;
   logic [DW-1:0]   exp_mul_r;
   logic [DW-1:0]   acc_r;
   logic [BW-1:0]   bit_r;
   logic            vld_r;
   logic            busy_r;
   logic            done_r;

   logic [DW-1:0]   cand_s;
   logic            cand_ok_s;
   logic [DW-1:0]   fa_red_s;
   logic [DW-1:0]   fb_red_s;
   logic [DW-1:0]   a_src_s;
   logic [DW-1:0]   b_src_s;
   logic [DW-1:0]   add_y_s;
   logic [DW-1:0]   sub_y_s;
   logic [DW:0]     half_sum_s;
   logic [DW-1:0]   half_s;
   logic [DW-1:0]   dbl_s;
   logic [DW-1:0]   dbl_add_s;
   logic [DW-1:0]   step_s;
   logic            last_s;

   assign cand_s    = lfsr_r[DW-1:0];
   assign cand_ok_s = (cand_s < Q_D);
   assign fa_red_s  = (fix_a >= Q_D) ? (fix_a - Q_D) : fix_a;
   assign fb_red_s  = (fix_b >= Q_D) ? (fix_b - Q_D) : fix_b;
   assign last_s    = fixed_r || (idx_r == IDX_LAST);

   // Directed operands feed the reducers at start; random ones while b is being accepted.
   always_comb begin
      if (state_r == ST_GEN_B) begin
         a_src_s = op_a_r;
         b_src_s = cand_s;
      end else begin
         a_src_s = fa_red_s;
         b_src_s = fb_red_s;
      end
   end

   // Halving adds Q to odd values so the shifted result stays exact.
   assign half_sum_s = {1'b0, a_src_s} + (a_src_s[0] ? Q_W : {(DW+1){1'b0}});
   assign half_s     = half_sum_s[DW:1];

   mod_addsub_q #(.DW(DW), .Q(Q)) u_add (.a(a_src_s), .b(b_src_s), .sub(1'b0), .y(add_y_s));
   mod_addsub_q #(.DW(DW), .Q(Q)) u_sub (.a(a_src_s), .b(b_src_s), .sub(1'b1), .y(sub_y_s));
   mod_addsub_q #(.DW(DW), .Q(Q)) u_dbl (.a(acc_r), .b(acc_r), .sub(1'b0), .y(dbl_s));
   mod_addsub_q #(.DW(DW), .Q(Q)) u_acc (.a(dbl_s), .b(op_a_r), .sub(1'b0), .y(dbl_add_s));

   assign step_s = op_b_r[bit_r] ? dbl_add_s : dbl_s;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (fixed) begin
                  state_next_s = ST_MUL;
               end else begin
                  state_next_s = ST_GEN_A;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_GEN_A: begin
            if (cand_ok_s) begin
               state_next_s = ST_GEN_B;
            end else begin
               state_next_s = ST_GEN_A;
            end
         end
         ST_GEN_B: begin
            if (cand_ok_s) begin
               state_next_s = ST_MUL;
            end else begin
               state_next_s = ST_GEN_B;
            end
         end
         ST_MUL: begin
            if (bit_r == {BW{1'b0}}) begin
               state_next_s = ST_OUT;
            end else begin
               state_next_s = ST_MUL;
            end
         end
         ST_OUT: begin
            if (rdy) begin
               if (last_s) begin
                  state_next_s = ST_DONE;
               end else begin
                  state_next_s = ST_GEN_A;
               end
            end else begin
               state_next_s = ST_OUT;
            end
         end
         ST_DONE:  state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // Operand, result, multiplier and LFSR datapath.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_r     <= SEED_EFF;
         idx_r      <= 16'd0;
         fixed_r    <= 1'b0;
         op_a_r     <= {DW{1'b0}};
         op_b_r     <= {DW{1'b0}};
         exp_add_r  <= {DW{1'b0}};
         exp_sub_r  <= {DW{1'b0}};
         exp_half_r <= {DW{1'b0}};
         exp_mul_r  <= {DW{1'b0}};
         acc_r      <= {DW{1'b0}};
         bit_r      <= BIT_TOP;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  idx_r   <= 16'd0;
                  fixed_r <= fixed;
                  acc_r   <= {DW{1'b0}};
                  bit_r   <= BIT_TOP;
                  if (fixed) begin
                     op_a_r     <= fa_red_s;
                     op_b_r     <= fb_red_s;
                     exp_add_r  <= add_y_s;
                     exp_sub_r  <= sub_y_s;
                     exp_half_r <= half_s;
                  end
               end
            end
            ST_GEN_A: begin
               lfsr_r <= lfsr_step(lfsr_r);
               if (cand_ok_s) begin
                  op_a_r <= cand_s;
               end
            end
            ST_GEN_B: begin
               lfsr_r <= lfsr_step(lfsr_r);
               if (cand_ok_s) begin
                  op_b_r     <= cand_s;
                  exp_add_r  <= add_y_s;
                  exp_sub_r  <= sub_y_s;
                  exp_half_r <= half_s;
                  acc_r      <= {DW{1'b0}};
                  bit_r      <= BIT_TOP;
               end
            end
            ST_MUL: begin
               acc_r <= step_s;
               if (bit_r == {BW{1'b0}}) begin
                  exp_mul_r <= step_s;
               end else begin
                  bit_r <= bit_r - {{(BW-1){1'b0}}, 1'b1};
               end
            end
            ST_OUT: begin
               if (rdy && !last_s) begin
                  idx_r <= idx_r + 16'd1;
               end
            end
            ST_DONE: begin
               fixed_r <= 1'b0;
            end
            default: begin
               fixed_r <= 1'b0;
            end
         endcase
      end
   end

   // Status flags are registered from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         vld_r  <= (state_next_s == ST_OUT);
         busy_r <= (state_next_s != ST_IDLE);
         done_r <= (state_next_s == ST_DONE);
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign vld      = vld_r;
   assign idx      = idx_r;
   assign op_a     = op_a_r;
   assign op_b     = op_b_r;
   assign exp_add  = exp_add_r;
   assign exp_sub  = exp_sub_r;
   assign exp_half = exp_half_r;
   assign exp_mul  = exp_mul_r;

endmodule

// File: tb/tb_modops_vec_gen.sv
// Self-checking bench for modops_vec_gen: directed table, randomized stalled run
// against an arithmetic reference model, and reset abort mid-multiply.
module tb_modops_vec_gen;

   localparam int Q  = 3329;
   localparam int NV = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        fixed = 1'b0;
   logic        rdy = 1'b0;
   logic [11:0] fix_a = 12'd0;
   logic [11:0] fix_b = 12'd0;
   logic        busy, done, vld;
   logic [15:0] idx;
   logic [11:0] op_a, op_b, exp_add, exp_sub, exp_half, exp_mul;

   modops_vec_gen #(.DW(12), .Q(Q), .SEED(16'hACE1), .NUM_VEC(NV)) dut (
      .clk(clk), .rst(rst), .start(start), .fixed(fixed),
      .fix_a(fix_a), .fix_b(fix_b), .busy(busy), .done(done), .vld(vld),
      .rdy(rdy), .idx(idx), .op_a(op_a), .op_b(op_b),
      .exp_add(exp_add), .exp_sub(exp_sub), .exp_half(exp_half), .exp_mul(exp_mul)
   );

   always #5 clk = ~clk;

   typedef struct {
      int a; int b; int add; int sub; int half; int mul;
   } vec_t;

   typedef struct {
      int fa; int fb; int a; int b; int add; int sub; int half; int mul;
   } fix_t;

   int checks = 0;
   int errors = 0;
   int lfsr_m;
   int first_lat, first_a, first_b, first_add, first_sub, first_half, first_mul;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, req);
      end
   endtask

   function automatic int m_next(input int s);
      if (s % 2 == 1) return (s / 2) ^ 32'h0000B400;
      return s / 2;
   endfunction

   // Rejection sampling: draw low 12 bits until below Q, advancing the register each draw.
   task automatic model_draw(output int c);
      c = Q;
      while (c >= Q) begin
         c = lfsr_m % 4096;
         lfsr_m = m_next(lfsr_m);
      end
   endtask

   function automatic vec_t model_vec(input int a, input int b);
      vec_t v;
      v.a = a; v.b = b;
      v.add  = (a + b) % Q;
      v.sub  = (a - b + Q) % Q;
      v.half = (a * 1665) % Q;   // 1665 is the inverse of 2 mod 3329
      v.mul  = (a * b) % Q;
      return v;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; start = 1'b0; rdy = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      lfsr_m = 32'h0000ACE1;
   endtask

   task automatic run(input bit fx, input bit stall, input int nvec, input vec_t fexp);
      int hs = 0;
      int ndone = 0;
      int cyc = 0;
      int budget;
      int ra, rb;
      bit seen = 1'b0;
      bit prev_hs = 1'b0;
      vec_t cur;
      logic [87:0] held;
      budget = nvec * 400 + 200;
      @(negedge clk);
      start = 1'b1; fixed = fx; rdy = 1'b0;
      while (ndone == 0 && cyc < budget) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (cyc == 1) chk("busy_after_start", busy, 1);
         if (prev_hs) chk("vld_drop_after_hs", vld, 0);
         if (done) begin
            ndone++;
            chk("done_after_last_hs", prev_hs, 1);
         end
         prev_hs = 1'b0;
         if (vld) begin
            if (!seen) begin
               seen = 1'b1;
               if (fx) begin
                  cur = fexp;
               end else begin
                  model_draw(ra);
                  model_draw(rb);
                  cur = model_vec(ra, rb);
               end
               if (hs == 0) begin
                  first_lat = cyc; first_a = op_a; first_b = op_b;
                  first_add = exp_add; first_sub = exp_sub;
                  first_half = exp_half; first_mul = exp_mul;
               end
               chk("idx", idx, hs);
               chk("op_a", op_a, cur.a);
               chk("op_b", op_b, cur.b);
               chk("exp_add", exp_add, cur.add);
               chk("exp_sub", exp_sub, cur.sub);
               chk("exp_half", exp_half, cur.half);
               chk("exp_mul", exp_mul, cur.mul);
               held = {idx, op_a, op_b, exp_add, exp_sub, exp_half, exp_mul};
            end else begin
               checks++;
               if ({idx, op_a, op_b, exp_add, exp_sub, exp_half, exp_mul} != held) begin
                  errors++;
                  $display("FAIL stall_hold actual %h required %h",
                           {idx, op_a, op_b, exp_add, exp_sub, exp_half, exp_mul}, held);
               end
            end
         end
         rdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (vld && rdy) begin
            hs++;
            seen = 1'b0;
            prev_hs = 1'b1;
         end
      end
      chk("run_completed", ndone, 1);
      chk("handshakes", hs, nvec);
      @(negedge clk);
      rdy = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("busy_low_after_done", busy, 0);
   endtask

   fix_t tbl[6];
   vec_t dummy;

   initial begin
      tbl[0] = '{3328, 3328, 3328, 3328, 3327,    0, 1664,    1};
      tbl[1] = '{1234, 2345, 1234, 2345,  250, 2218,  617,  829};
      tbl[2] = '{   1,    0,    1,    0,    1,    1, 1665,    0};
      tbl[3] = '{4095,    1,  766,    1,  767,  765,  383,  766};
      tbl[4] = '{3329,    0,    0,    0,    0,    0,    0,    0};
      tbl[5] = '{   2, 3328,    2, 3328,    1,    3,    1, 3327};
      dummy  = '{0, 0, 0, 0, 0, 0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_vld", vld, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_idx", idx, 0);
      chk("rst_op_a", op_a, 0);
      chk("rst_exp_mul", exp_mul, 0);
      rst = 1'b1;
      lfsr_m = 32'h0000ACE1;

      // Directed vectors (do not touch the LFSR)
      for (int i = 0; i < 6; i++) begin
         vec_t e;
         e = '{tbl[i].a, tbl[i].b, tbl[i].add, tbl[i].sub, tbl[i].half, tbl[i].mul};
         fix_a = 12'(tbl[i].fa);
         fix_b = 12'(tbl[i].fb);
         run(1'b1, 1'b0, 1, e);
      end

      // Full random run with stalls; first vector also against known constants
      run(1'b0, 1'b1, NV, dummy);
      chk("first_latency", first_lat, 15);
      chk("first_a", first_a, 3297);
      chk("first_b", first_b, 624);
      chk("first_add", first_add, 592);
      chk("first_sub", first_sub, 2673);
      chk("first_half", first_half, 3313);
      chk("first_mul", first_mul, 6);

      // Reset while multiplying aborts without a done pulse
      do_reset();
      @(negedge clk);
      start = 1'b1; fixed = 1'b0;
      repeat (5) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b0;
      #1;
      chk("abort_vld", vld, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_op_a", op_a, 0);
      begin
         int nd = 0;
         repeat (3) @(negedge clk);
         rst = 1'b1;
         lfsr_m = 32'h0000ACE1;
         repeat (3) begin
            @(negedge clk);
            if (done || busy) nd++;
         end
         chk("abort_quiet_after_release", nd, 0);
      end

      // Next run reproduces the seed sequence
      run(1'b0, 1'b0, NV, dummy);
      chk("rerun_first_latency", first_lat, 15);
      chk("rerun_first_a", first_a, 3297);
      chk("rerun_first_b", first_b, 624);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/modops_vec_gen.md
# modops_vec_gen

Synthesizable vector source for the modular-arithmetic datapath (q = 3329, 12-bit). It produces pseudo-random operand pairs in [0, q) and computes golden expected results for modular add, subtract, half and multiply, using its own sequential reference arithmetic. Results are emitted over a valid/ready stream. It is the producing end of the add/sub/half/mul check flow: it drives the modular-op units in on-chip self-test and feeds vector dumps for simulation.

## Interface
- DW, 12, operand/result width
- Q, 3329, modulus; must satisfy Q < 2^DW
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001
- NUM_VEC, 1024, vectors emitted per random run (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-low
- start  in  1  begin a run; sampled only in IDLE
- fixed  in  1  sampled with start: 1 = one vector from fix_a/fix_b, 0 = NUM_VEC random vectors
- fix_a, fix_b  in  DW  directed operands
- busy  out  1  high from the cycle after start is accepted until DONE is left
- done  out  1  one-cycle pulse at run end
- vld  out  1  vector valid
- rdy  in  1  consumer ready
- idx  out  16  index of current vector within the run
- op_a, op_b  out  DW  operands
- exp_add, exp_sub, exp_half, exp_mul  out  DW  (a+b) mod Q, (a−b) mod Q, a·2⁻¹ mod Q, a·b mod Q

## Operation
- FSM states: IDLE → GEN_A → GEN_B → MUL → OUT → (GEN_A | DONE) → IDLE. In fixed mode, IDLE goes directly to MUL.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right. Next state is (s>>1) ^ (s[0] ? 16'hB400 : 0).
  - Advances every cycle in GEN_A and GEN_B, and only then.
  - Reset to SEED only by rst; continues across runs.
- GEN_A: candidate = lfsr[DW-1:0]. If candidate < Q, op_a ← candidate and go to GEN_B; otherwise reject and stay.
- GEN_B: same rule into op_b. On acceptance, register exp_add, exp_sub and exp_half, then go to MUL.
- Fixed mode: operands are loaded at start. Any operand ≥ Q is reduced by a single subtraction of Q.
- Arithmetic:
  - add: s = a+b in DW+1 bits; subtract Q if s ≥ Q.
  - sub: a−b; add Q if a < b.
  - half: a even → a>>1; a odd → (a+Q)>>1 in DW+1 bits.
- MUL: MSB-first double-and-add over DW cycles, acc starting at 0. For bit i = DW−1 down to 0:
  - acc ← 2·acc mod Q
  - then, if b[i] = 1, acc ← (acc + a) mod Q
  - Each step is a conditional single subtraction. After the last bit, exp_mul ← acc.
- OUT: vld = 1. On vld && rdy:
  - If idx = NUM_VEC−1, or in fixed mode → DONE.
  - Otherwise idx++ and go to GEN_A.
- DONE: done = 1 for one cycle, then IDLE. idx clears to 0 on the next start.
- start is ignored outside IDLE. rdy is ignored outside OUT.

## Timing
- Reset values: vld = 0, done = 0, busy = 0, idx = 0, all data outputs 0, LFSR = SEED, state IDLE.
- Reset during a run aborts immediately. No done pulse is produced; the partial vector is discarded.
- Per-vector latency is (GEN_A cycles + GEN_B cycles) + DW + 1 cycles to vld. Minimum is 1 + 1 + 12 + 1 = 15 cycles.
- While vld && !rdy, all data outputs and idx hold stable.
- vld falls in the cycle after the handshake; there are no back-to-back vectors.
- Rejections extend GEN_A/GEN_B by one cycle each; there is no upper bound.
- done rises the cycle after the final handshake.

## Structure
- Shared package `modops_pkg`: Q, DW, LFSR mask, state encoding.
- One sub-module, `mod_addsub_q`: conditional-subtract/add reducer. It is reused by add, sub and every mul step.
- The multiplier step counter, LFSR and FSM live in the top level.

## Test plan
- Reset, then start with fixed=0, rdy=1 → first vector is a=3297, b=624:
  - add=592, sub=2673, half=3313, mul=6, idx=0.
  - vld is asserted 15 cycles after the start cycle.
- Fixed a=3328, b=3328 → add=3327, sub=0, half=1664, mul=1; done pulses once; busy then low.
- Fixed a=1234, b=2345 → mul=829.
- Fixed a=1, b=0 → add=1, sub=1, half=1665, mul=0.
- Fixed a=4095 (reduced to 766), b=1 → add=767, mul=766.
- NUM_VEC=1024 run with random rdy stalls, checked against a software model:
  - 1024 handshakes, idx from 0 to 1023, every result < Q.
  - Outputs stable during stalls.
  - Exactly one done pulse.
- rst asserted while in MUL → vld=0, busy=0, no done pulse.
  - After release, the next run reproduces a=3297, b=624.
